// File: rtl/encoder_emitter_if.sv
// Command handshake bundle for encoder_emitter: the master issues a detent
// count and direction, the slave (the emitter) reports when it can accept one.
interface encoder_emitter_if #(
    parameter int COUNT_W = 8
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [COUNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/encoder_emitter.sv
// encoder_emitter: emits a commanded number of quadrature detents on enc_a/enc_b
// and tracks the signed net position. Define ENCODER_EMITTER_BOUNCE_EN for contact bounce.
module encoder_emitter #(
    parameter int PHASE_CYCLES = 16,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    encoder_emitter_if.slave   cmd,
    output logic               enc_a,
    output logic               enc_b,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pos
);
    localparam logic [0:0]         ST_IDLE      = 1'b0;
    localparam logic [0:0]         ST_RUN       = 1'b1;
    localparam logic [15:0]        TIMER_RELOAD = 16'(PHASE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_ONE      = COUNT_W'(1);

    logic [0:0]         state;
    logic [15:0]        timer;
    logic [1:0]         phase;
    logic               dir_q;
    logic [COUNT_W-1:0] remaining;

    logic               step;
    logic [1:0]         phase_next;
    logic               detent_end;
    logic [1:0]         next_ab;

    // Phase index 0..3 maps onto the forward Gray sequence 00,10,11,01.
    function automatic logic [1:0] ab_of(input logic [1:0] p);
        case (p)
            2'd0:    ab_of = 2'b00;
            2'd1:    ab_of = 2'b10;
            2'd2:    ab_of = 2'b11;
            default: ab_of = 2'b01;
        endcase
    endfunction

    assign cmd.cmd_ready = (state == ST_IDLE);

    always_comb begin
        step       = (state == ST_RUN) && (timer == 16'd0);
        phase_next = dir_q ? (phase + 2'd1) : (phase - 2'd1);
        detent_end = step && (phase_next == 2'd0);
        next_ab    = ab_of(phase_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            phase     <= '0;
            dir_q     <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        dir_q     <= cmd.cmd_dir;
                        remaining <= cmd.cmd_count;
                        if (cmd.cmd_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            timer <= TIMER_RELOAD;
                        end
                    end
                end
                default: begin
                    if (step) begin
                        timer <= TIMER_RELOAD;
                        phase <= phase_next;
                        // Remaining counts down per detent, so a full-scale count never overflows.
                        if (detent_end) begin
                            pos       <= dir_q ? (pos + CNT_ONE) : (pos - CNT_ONE);
                            remaining <= remaining - CNT_ONE;
                            if (remaining == CNT_ONE) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef ENCODER_EMITTER_BOUNCE_EN
    logic [1:0] bounce_stage;
    logic [1:0] settled_ab;
    logic [1:0] bounce_mask;

    // The changing channel reads new, old, new on t, t+1, t+2; PHASE_CYCLES >= 4 keeps bounces apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            {enc_a, enc_b} <= 2'b00;
            bounce_stage   <= 2'd0;
            settled_ab     <= 2'b00;
            bounce_mask    <= 2'b00;
        end else if (step) begin
            {enc_a, enc_b} <= next_ab;
            settled_ab     <= next_ab;
            bounce_mask    <= next_ab ^ ab_of(phase);
            bounce_stage   <= 2'd1;
        end else if (bounce_stage == 2'd1) begin
            {enc_a, enc_b} <= settled_ab ^ bounce_mask;
            bounce_stage   <= 2'd2;
        end else if (bounce_stage == 2'd2) begin
            {enc_a, enc_b} <= settled_ab;
            bounce_stage   <= 2'd0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            {enc_a, enc_b} <= 2'b00;
        end else if (step) begin
            {enc_a, enc_b} <= next_ab;
        end
    end
`endif
endmodule

// File: tb/tb_encoder_emitter.sv
// Self-checking bench for encoder_emitter: table of commands plus hand sequences,
// with a scoreboard of expected quadrature steps and done pulses timed in cycles.
module tb_encoder_emitter;
    localparam int PHASE = 16;
    localparam int CW    = 8;

    typedef struct {
        logic [1:0] ab;
        int         cyc;
    } step_t;

    typedef struct {
        logic          dir;
        logic [CW-1:0] count;
        logic [CW-1:0] exp_pos;
        int            exp_busy;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enc_a;
    logic          enc_b;
    logic          busy;
    logic          done;
    logic [CW-1:0] pos;

    encoder_emitter_if #(.COUNT_W(CW)) cmd_bus ();

    encoder_emitter #(
        .PHASE_CYCLES(PHASE),
        .COUNT_W     (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .cmd  (cmd_bus),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .busy (busy),
        .done (done),
        .pos  (pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    step_t      step_q[$];
    int         done_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    bit         mon_en = 1'b0;
    bit         in_bounce;
    logic [1:0] prev_ab = 2'b00;
    logic       prev_done = 1'b0;
    int         last_pop_cyc = -10;
    int         last_done_cyc = -10;
    int         busy_cnt = 0;
    int         acc_cyc = 0;
    logic [1:0] fwd_seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] rev_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    vec_t       vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_vec++;
        if (actual !== required) begin
            n_miss++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, actual, required);
        end
    endtask

    // Monitor: every AB change and done pulse must match the head of its queue, to the cycle.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_ab   = {enc_a, enc_b};
            prev_done = done;
        end else begin
            if (busy) busy_cnt++;
            in_bounce = 1'b0;
`ifdef ENCODER_EMITTER_BOUNCE_EN
            in_bounce = (cyc == last_pop_cyc + 1) || (cyc == last_pop_cyc + 2);
`endif
            if (({enc_a, enc_b} != prev_ab) && !in_bounce) begin
                if (step_q.size() == 0) begin
                    checkOutput("unexpected_step", {30'd0, enc_a, enc_b}, {30'd0, prev_ab});
                end else begin
                    step_t s;
                    s = step_q.pop_front();
                    checkOutput("step_ab", {30'd0, enc_a, enc_b}, {30'd0, s.ab});
                    checkOutput("step_cycle", cyc, s.cyc);
                    last_pop_cyc = cyc;
                end
            end
            if (done) begin
                checkOutput("done_width", {31'd0, prev_done}, 32'd0);
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    checkOutput("done_cycle", cyc, d);
                    last_done_cyc = cyc;
                end
            end
            prev_ab   = {enc_a, enc_b};
            prev_done = done;
        end
    end

    task automatic issueCmd(input logic dir, input logic [CW-1:0] count);
        bit    got;
        step_t s;
        got = 1'b0;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_dir   = dir;
        cmd_bus.cmd_count = count;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_bus.cmd_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checkOutput("accept_timeout", {31'd0, cmd_bus.cmd_ready}, 32'd1);
            cmd_bus.cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        for (int k = 0; k < 4 * int'(count); k++) begin
            s.ab  = dir ? fwd_seq[k % 4] : rev_seq[k % 4];
            s.cyc = acc_cyc + PHASE * (k + 1);
            step_q.push_back(s);
        end
        done_q.push_back((count == '0) ? acc_cyc : acc_cyc + 4 * PHASE * int'(count));
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_dir   = ~dir;
        cmd_bus.cmd_count = ~count;
    endtask

    task automatic waitIdle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && step_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", int'(busy) + step_q.size() + done_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        mon_en            = 1'b0;
        reset             = 1'b1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_dir   = 1'b1;
        cmd_bus.cmd_count = 8'd3;
        repeat (2) @(negedge clk);
        checkOutput("rst_ab", {30'd0, enc_a, enc_b}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_pos", {24'd0, pos}, 32'd0);
        step_q.delete();
        done_q.delete();
        reset             = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        checkOutput("rst_idle_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        busy_cnt = 0;
        issueCmd(v.dir, v.count);
        waitIdle(4 * PHASE * int'(v.count) + 200);
        checkOutput("pos", {24'd0, pos}, {24'd0, v.exp_pos});
        checkOutput("busy_cycles", busy_cnt, v.exp_busy);
        checkOutput("ready_idle", {31'd0, cmd_bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{dir: 1'b1, count: 8'd1,   exp_pos: 8'h01, exp_busy: 64};
        vecs[1] = '{dir: 1'b0, count: 8'd3,   exp_pos: 8'hFE, exp_busy: 192};
        vecs[2] = '{dir: 1'b1, count: 8'd0,   exp_pos: 8'hFE, exp_busy: 0};
        vecs[3] = '{dir: 1'b1, count: 8'd2,   exp_pos: 8'h00, exp_busy: 128};
        vecs[4] = '{dir: 1'b0, count: 8'd1,   exp_pos: 8'hFF, exp_busy: 64};
        vecs[5] = '{dir: 1'b1, count: 8'd255, exp_pos: 8'hFE, exp_busy: 16320};

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_dir   = 1'b0;
        cmd_bus.cmd_count = '0;

        resetDut();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Back-to-back: second command waits with valid held and is taken in the done cycle.
        issueCmd(1'b0, 8'd1);
        issueCmd(1'b1, 8'd2);
        checkOutput("b2b_accept_cycle", acc_cyc, last_done_cyc + 1);
        waitIdle(400);
        checkOutput("b2b_pos", {24'd0, pos}, 32'h0000_00FF);

        // Reset in the middle of a run: abort with no done and no further steps.
        issueCmd(1'b1, 8'd5);
        repeat (40) @(negedge clk);
        resetDut();
        repeat (100) @(negedge clk);
        checkOutput("abort_pos", {24'd0, pos}, 32'd0);

        issueCmd(1'b1, 8'd1);
        waitIdle(300);
        checkOutput("post_rst_pos", {24'd0, pos}, 32'd1);

`ifdef ENCODER_EMITTER_BOUNCE_EN
        issueCmd(1'b1, 8'd1);
        for (int i = 0; i < 40; i++) begin
            int off;
            @(negedge clk);
            off = cyc - acc_cyc;
            if (off == 16 || off == 18) checkOutput("bounce_a_new", {31'd0, enc_a}, 32'd1);
            if (off == 17)              checkOutput("bounce_a_old", {31'd0, enc_a}, 32'd0);
            if (off == 32 || off == 34) checkOutput("bounce_b_new", {31'd0, enc_b}, 32'd1);
            if (off == 33)              checkOutput("bounce_b_old", {31'd0, enc_b}, 32'd0);
        end
        waitIdle(300);
        checkOutput("bounce_pos", {24'd0, pos}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
